// File: rtl/ws2812_frame_controller_if.sv
// Pixel stream (valid/ready) and bit-generator links of the WS2812 frame controller.
// master = controller side, slave = pixel source / bit generator side.
interface ws2812_frame_controller_if;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [1:0]  gen_mode;
  logic        do_gen;
  logic        gen_done;

  modport master (
    input  pix_data, pix_valid, gen_done,
    output pix_ready, gen_mode, do_gen
  );

  modport slave (
    output pix_data, pix_valid, gen_done,
    input  pix_ready, gen_mode, do_gen
  );
endinterface

// File: rtl/ws2812_frame_controller.sv
// ws2812_frame_controller: sequences one WS2812B frame. Pulls GRB pixels over
// valid/ready, serialises them MSB-first into the bit generator, then holds
// the line low for RESET_CYCLES and pulses frame_done.
// Optional feature: define WS2812_UNDERRUN_FLAG_EN to add the underrun pulse
// and the saturating underrun_cnt outputs.
module ws2812_frame_controller #(
  parameter int unsigned LED_CNT_W    = 10,
  parameter int unsigned RESET_CYCLES = 6000,
  parameter int unsigned BITS_PER_LED = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [LED_CNT_W-1:0]      num_leds,
  ws2812_frame_controller_if.master pixGen,
  output logic                      busy,
  output logic                      frame_done
`ifdef WS2812_UNDERRUN_FLAG_EN
  ,
  output logic                      underrun,
  output logic [15:0]               underrun_cnt
`endif
);

  localparam int unsigned BIT_CNT_W   = $clog2(BITS_PER_LED);
  localparam int unsigned LATCH_CNT_W = $clog2(RESET_CYCLES);
  localparam int unsigned LED_EXT_W   = LED_CNT_W + 1;
  localparam logic [1:0]  MODE_RET    = 2'b00;
  localparam logic [1:0]  MODE_NONE   = 2'b01;

  typedef enum logic [2:0] {IDLE, FETCH, SEND, LATCH, DONE} stateT;

  stateT                   state, stateNext;
  logic [BITS_PER_LED-1:0] shiftReg, shiftNext;
  logic [BITS_PER_LED-1:0] holdReg, holdNext;
  logic                    holdFull, holdFullNext;
  logic [BIT_CNT_W-1:0]    bitCnt, bitCntNext;
  logic [LED_CNT_W-1:0]    ledCnt, ledCntNext;
  logic [LED_CNT_W-1:0]    numLeds, numLedsNext;
  logic [LATCH_CNT_W-1:0]  latchCnt, latchCntNext;

  logic                    pixReadyQ, pixReadyNext;
  logic [1:0]              genModeQ, genModeNext;
  logic                    doGenQ, doGenNext;
  logic                    busyQ, busyNext;
  logic                    frameDoneQ, frameDoneNext;

  logic                    pixAccept;
  logic                    lastBit;
  logic                    lastLed;
  logic                    morePix;

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shiftReg   <= '0;
      holdReg    <= '0;
      holdFull   <= 1'b0;
      bitCnt     <= '0;
      ledCnt     <= '0;
      numLeds    <= '0;
      latchCnt   <= '0;
      pixReadyQ  <= 1'b0;
      genModeQ   <= MODE_NONE;
      doGenQ     <= 1'b0;
      busyQ      <= 1'b0;
      frameDoneQ <= 1'b0;
    end else begin
      state      <= stateNext;
      shiftReg   <= shiftNext;
      holdReg    <= holdNext;
      holdFull   <= holdFullNext;
      bitCnt     <= bitCntNext;
      ledCnt     <= ledCntNext;
      numLeds    <= numLedsNext;
      latchCnt   <= latchCntNext;
      pixReadyQ  <= pixReadyNext;
      genModeQ   <= genModeNext;
      doGenQ     <= doGenNext;
      busyQ      <= busyNext;
      frameDoneQ <= frameDoneNext;
    end
  end

  // Next state, datapath updates and next-cycle output decode.
  always_comb begin
    stateNext     = state;
    shiftNext     = shiftReg;
    holdNext      = holdReg;
    holdFullNext  = holdFull;
    bitCntNext    = bitCnt;
    ledCntNext    = ledCnt;
    numLedsNext   = numLeds;
    latchCntNext  = latchCnt;

    pixAccept = pixReadyQ && pixGen.pix_valid;
    lastBit   = (bitCnt == BIT_CNT_W'(BITS_PER_LED - 1));
    lastLed   = ((ledCnt + LED_CNT_W'(1)) == numLeds);

    case (state)
      IDLE: begin
        if (start) begin
          numLedsNext  = num_leds;
          ledCntNext   = '0;
          bitCntNext   = '0;
          holdFullNext = 1'b0;
          latchCntNext = '0;
          stateNext    = (num_leds == '0) ? LATCH : FETCH;
        end
      end
      FETCH: begin
        if (pixAccept) begin
          shiftNext  = BITS_PER_LED'(pixGen.pix_data);
          bitCntNext = '0;
          stateNext  = SEND;
        end
      end
      SEND: begin
        if (pixAccept) begin
          holdNext     = BITS_PER_LED'(pixGen.pix_data);
          holdFullNext = 1'b1;
        end
        if (pixGen.gen_done) begin
          if (lastBit) begin
            ledCntNext = ledCnt + LED_CNT_W'(1);
            bitCntNext = '0;
            if (lastLed) begin
              latchCntNext = '0;
              stateNext    = LATCH;
            end else if (holdFull) begin
              shiftNext    = holdReg;
              holdFullNext = 1'b0;
            end else if (pixAccept) begin
              // pixel arrived on the LED boundary: straight into the shifter
              shiftNext    = BITS_PER_LED'(pixGen.pix_data);
              holdFullNext = 1'b0;
            end else begin
              stateNext = FETCH;
            end
          end else begin
            shiftNext  = shiftReg << 1;
            bitCntNext = bitCnt + BIT_CNT_W'(1);
          end
        end
      end
      LATCH: begin
        if (latchCnt == LATCH_CNT_W'(RESET_CYCLES - 1)) begin
          latchCntNext = '0;
          stateNext    = DONE;
        end else begin
          latchCntNext = latchCnt + LATCH_CNT_W'(1);
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    morePix = ((LED_EXT_W'(ledCntNext) + LED_EXT_W'(1)) < LED_EXT_W'(numLedsNext));

    pixReadyNext  = (stateNext == FETCH) ||
                    ((stateNext == SEND) && !holdFullNext && morePix);
    doGenNext     = (stateNext == SEND);
    genModeNext   = (stateNext == SEND)  ? {1'b1, shiftNext[BITS_PER_LED-1]} :
                    (stateNext == LATCH) ? MODE_RET : MODE_NONE;
    busyNext      = (stateNext != IDLE);
    frameDoneNext = (stateNext == DONE);
  end

  assign pixGen.pix_ready = pixReadyQ;
  assign pixGen.gen_mode  = genModeQ;
  assign pixGen.do_gen    = doGenQ;
  assign busy             = busyQ;
  assign frame_done       = frameDoneQ;

`ifdef WS2812_UNDERRUN_FLAG_EN
  logic        underrunEvt;
  logic        underrunQ;
  logic [15:0] underrunCntQ;

  assign underrunEvt = (state == SEND) && (stateNext == FETCH);

  // Underrun pulse and saturating event counter; only reset clears the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrunQ    <= 1'b0;
      underrunCntQ <= '0;
    end else begin
      underrunQ <= underrunEvt;
      if (underrunEvt && (underrunCntQ != 16'hFFFF)) begin
        underrunCntQ <= underrunCntQ + 16'd1;
      end
    end
  end

  assign underrun     = underrunQ;
  assign underrun_cnt = underrunCntQ;
`endif

endmodule

// File: tb/tb_ws2812_frame_controller.sv
// Self-checking bench for ws2812_frame_controller: a pixel source and a bit
// generator model drive the DUT; a monitor checks every cycle against a
// queue-based model of the serialised bit stream and frame rules.
`timescale 1ns/1ps
module tb_ws2812_frame_controller;

  localparam int RESET_CYCLES = 6000;

  logic       clk;
  logic       reset;
  logic       start;
  logic [9:0] num_leds;
  logic       busy;
  logic       frame_done;
`ifdef WS2812_UNDERRUN_FLAG_EN
  logic        underrun;
  logic [15:0] underrun_cnt;
`endif

  ws2812_frame_controller_if bus();

  ws2812_frame_controller dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_leds    (num_leds),
    .pixGen      (bus),
    .busy        (busy),
    .frame_done  (frame_done)
`ifdef WS2812_UNDERRUN_FLAG_EN
    ,
    .underrun    (underrun),
    .underrun_cnt(underrun_cnt)
`endif
  );

  int nChk = 0;
  int nErr = 0;

  // frame description shared with the pixel source
  logic [23:0] frmPix [16];
  int          frmDly [16];
  int          frmN   = 0;
  int          srcGen = 0;
  int          genLat = 4;

  // model state observed by the main sequence
  int          hsCnt    = 0;
  int          fdCnt    = 0;
  int          fdCyc    = 0;
  int          startCyc = 0;
  int          cyc      = 0;
  int          bitsDone = 0;
  int          frmHs    = 0;
  int          curNum   = 0;
  int          midLow   = 0;
  int          undFrm   = 0;
  logic [1:0]  modeSeq [$];

  logic [1:0] t1Seq [24] = '{
    2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b10, 2'b11,
    2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11,
    2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};

  task automatic chk(input string name, input longint got, input longint exp);
    nChk++;
    if (got !== exp) begin
      nErr++;
      if (nErr <= 30) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit generator: gen_done after genLat cycles of do_gen; random noise when idle.
  initial begin : generator
    int c;
    c = 0;
    bus.gen_done = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus.gen_done = 1'b0;
      if (bus.do_gen) begin
        c++;
        if (c >= genLat) begin
          bus.gen_done = 1'b1;
          c = 0;
        end
      end else begin
        c = 0;
        bus.gen_done = ($urandom_range(0, 7) == 0);
      end
    end
  end

  // Pixel source: offers frmPix[i] frmDly[i] cycles after the previous handshake.
  initial begin : source
    int idx, waitC, seenHs, gen;
    idx = 0; waitC = 0; seenHs = 0; gen = 0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    forever begin
      @(posedge clk); #2;
      if (gen != srcGen) begin
        gen = srcGen; idx = 0; waitC = 0; seenHs = hsCnt;
        bus.pix_valid = 1'b0;
      end else if (hsCnt != seenHs) begin
        seenHs = hsCnt; idx++; waitC = 0;
        bus.pix_valid = 1'b0;
      end
      if (!bus.pix_valid && idx < frmN) begin
        if (waitC >= frmDly[idx]) begin
          bus.pix_data  = frmPix[idx];
          bus.pix_valid = 1'b1;
        end else begin
          waitC++;
        end
      end
    end
  end

  // Monitor: checks DUT outputs against the bit-queue model every cycle.
  initial begin : monitor
    bit   expBits [$];
    bit   expBusy, busyNow, prevRst, prevDoGen, isFetch, undEvt, eb;
    int   latchRun, held, undTot;
    expBusy = 0; prevRst = 0; prevDoGen = 0; latchRun = 0; undTot = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (prevRst) begin
        chk("rst_pix_ready", bus.pix_ready, 0);
        chk("rst_do_gen", bus.do_gen, 0);
        chk("rst_gen_mode", bus.gen_mode, 1);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
`ifdef WS2812_UNDERRUN_FLAG_EN
        chk("rst_underrun", underrun, 0);
        chk("rst_underrun_cnt", underrun_cnt, 0);
`endif
      end
      if (reset) begin
        expBits.delete();
        expBusy = 0; bitsDone = 0; frmHs = 0; latchRun = 0; undTot = 0;
        prevDoGen = 0; prevRst = 1;
      end else begin
        prevRst = 0;
        busyNow = expBusy;
        chk("busy", busy, busyNow);
        isFetch = busyNow && !bus.do_gen && bus.gen_mode == 2'b01 && !frame_done;
        if (bus.do_gen) begin
          chk("send_mode_msb", bus.gen_mode[1], 1);
          held = frmHs - bitsDone / 24 - 1;
          chk("send_pix_ready", bus.pix_ready, (held == 0 && frmHs < curNum) ? 1 : 0);
        end else begin
          chk("mode_msb_low", bus.gen_mode[1], 0);
          chk("pix_ready", bus.pix_ready, isFetch ? 1 : 0);
        end
        if (!busyNow) chk("idle_mode", bus.gen_mode, 1);
        if (frame_done) chk("done_in_frame", busyNow, 1);

        if (bus.do_gen && bus.gen_done) begin
          if (expBits.size() == 0) begin
            chk("bit_underflow", expBits.size(), 1);
          end else begin
            eb = expBits.pop_front();
            chk("bit_value", bus.gen_mode[0], eb);
          end
          modeSeq.push_back(bus.gen_mode);
          bitsDone++;
        end
        if (bus.pix_valid && bus.pix_ready) begin
          for (int i = 23; i >= 0; i--) expBits.push_back(bus.pix_data[i]);
          frmHs++;
          hsCnt++;
        end

        undEvt = isFetch && bitsDone > 0 && prevDoGen;
        if (isFetch && bitsDone > 0) midLow++;
        if (undEvt) begin
          undFrm++;
          if (undTot < 65535) undTot++;
        end
`ifdef WS2812_UNDERRUN_FLAG_EN
        chk("underrun_pulse", underrun, undEvt);
        chk("underrun_cnt", underrun_cnt, undTot);
`endif
        prevDoGen = bus.do_gen;

        if (frame_done) begin
          chk("latch_len", latchRun, RESET_CYCLES);
          chk("frame_pixels", frmHs, curNum);
          chk("frame_bits", bitsDone, 24 * curNum);
          chk("bits_left", expBits.size(), 0);
          fdCnt++;
          fdCyc = cyc;
        end
        if (bus.gen_mode == 2'b00) latchRun++;
        else latchRun = 0;

        if (start && !busyNow) begin
          expBusy = 1; curNum = num_leds; frmHs = 0; bitsDone = 0;
          modeSeq.delete(); midLow = 0; undFrm = 0; startCyc = cyc;
          expBits.delete();
        end else if (frame_done) begin
          expBusy = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic pulseReset();
    reset = 1'b1; tick(1); reset = 1'b0;
  endtask

  task automatic pulseStart(input int n);
    num_leds = 10'(n); start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic setupFrame(input int n, input int lat);
    frmN = n; genLat = lat; srcGen++;
    tick(2);
  endtask

  task automatic waitFrame(input int fd0, input int budget);
    int n;
    n = 0;
    while (fdCnt == fd0 && n < budget) begin tick(1); n++; end
    chk("frame_done_seen", fdCnt - fd0, 1);
    if (fdCnt == fd0) begin
      frmN = 0; srcGen++;
      pulseReset();
      tick(2);
    end
  endtask

  task automatic runFrame(input int n, input int lat);
    int fd0;
    setupFrame(n, lat);
    fd0 = fdCnt;
    pulseStart(n);
    waitFrame(fd0, 20000);
    tick(2);
  endtask

  initial begin : mainSeq
    int fd0, n, lat;
    reset = 1'b1; start = 1'b0; num_leds = '0;
    for (int i = 0; i < 16; i++) begin frmPix[i] = '0; frmDly[i] = 0; end
    tick(4);
    reset = 1'b0;
    tick(2);

    // single LED, slow generator: literal bit pattern
    frmPix[0] = 24'hA50F0F; frmDly[0] = 0;
    runFrame(1, 122);
    chk("t1_bit_count", modeSeq.size(), 24);
    for (int i = 0; i < 24 && i < modeSeq.size(); i++) chk("t1_mode", modeSeq[i], t1Seq[i]);

    // three LEDs, valid held high: gapless stream
    for (int i = 0; i < 3; i++) begin frmPix[i] = 24'($urandom); frmDly[i] = 0; end
    runFrame(3, 4);
    chk("t2_handshakes", frmHs, 3);
    chk("t2_gapless", midLow, 0);
    chk("t2_underruns", undFrm, 0);

    // second pixel late: one underrun with the line low while waiting
    frmPix[0] = 24'h123456; frmDly[0] = 0;
    frmPix[1] = 24'hFEDCBA; frmDly[1] = 500;
    runFrame(2, 4);
    chk("t3_underruns", undFrm, 1);
    chk("t3_wait_low", (midLow >= 350) ? 1 : 0, 1);

    // zero-LED frame goes straight to latch
    runFrame(0, 4);
    chk("t4_handshakes", frmHs, 0);
    chk("t4_bits", bitsDone, 0);
    // start cycle through frame_done cycle inclusive spans RESET_CYCLES+2
    chk("t4_done_delay", fdCyc - startCyc, RESET_CYCLES + 1);

    // reset in the middle of SEND at bit 10
    for (int i = 0; i < 3; i++) begin frmPix[i] = 24'($urandom); frmDly[i] = 0; end
    setupFrame(3, 4);
    fd0 = fdCnt;
    pulseStart(3);
    n = 0;
    while (bitsDone < 10 && n < 3000) begin tick(1); n++; end
    chk("t5_reached_bit10", bitsDone, 10);
    frmN = 0; srcGen++;
    pulseReset();
    tick(3);
    chk("t5_no_frame_done", fdCnt, fd0);
    for (int i = 0; i < 2; i++) begin frmPix[i] = 24'($urandom); frmDly[i] = 1; end
    runFrame(2, 5);
    chk("t5_refill_pixels", frmHs, 2);

    // start while busy is dropped
    for (int i = 0; i < 2; i++) begin frmPix[i] = 24'($urandom); frmDly[i] = 0; end
    setupFrame(2, 3);
    fd0 = fdCnt;
    pulseStart(2);
    tick(20);
    pulseStart(5);
    waitFrame(fd0, 20000);
    tick(30);
    chk("t6_single_done", fdCnt - fd0, 1);
    chk("t6_pixels", frmHs, 2);

    // randomized frames
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 6);
      lat = $urandom_range(2, 6);
      for (int i = 0; i < n; i++) begin
        frmPix[i] = 24'($urandom);
        frmDly[i] = ($urandom_range(0, 4) == 0) ? $urandom_range(20, 150) : $urandom_range(0, 3);
      end
      runFrame(n, lat);
    end

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule
